alu_ctrl_seq: RTL

Second-generation ALU controller for the single-cycle/pipelined MIPS datapath. It decodes `funct_i` and `ALUOp_i` into an ALU control code, as the first-generation controller does. It adds the HI/LO multiply/divide group and a cycle-counting sequencer that tracks the multi-cycle unit's latency. The sequencer stalls only dependent instructions and pulses the HI/LO write at completion. It sits between the main decoder and the ALU / multiply-divide unit in the EX stage.

---
 rtl/alu_ctrl_pkg.sv | 46 ++++
 rtl/md_seq_counter.sv | 34 +++
 rtl/alu_ctrl_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU controller: ALU codes, funct/ALUOp values, sequencer states.
// Consumers may be built with ALU_CTRL_DIV_EN to enable the divide group.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;
  localparam logic [3:0] ALU_DIV  = 4'b1101;
  localparam logic [3:0] ALU_MFHI = 4'b1110;
  localparam logic [3:0] ALU_MFLO = 4'b1111;

  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_SLTIU = 3'b011;
  localparam logic [2:0] OP_ORI   = 3'b100;
  localparam logic [2:0] OP_LUI   = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MD   = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_seq_counter.sv
// Loadable down-counter tracking multiply/divide latency; abort clears it at once.
module md_seq_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             abort,
  output logic             busy,
  output logic             last
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: saturates at zero, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (abort) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != {CNT_W{1'b0}});
  assign last = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with HI/LO multiply/divide sequencer for the EX stage.
// Define ALU_CTRL_DIV_EN to decode and sequence div/divu.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W             = 6,
  parameter int ALUOP_W             = 3,
  parameter int CTRL_W              = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               illegal_o,
  output logic               md_start_o,
  output logic               md_div_o,
  output logic               md_signed_o,
  output logic               busy_o,
  output logic               stall_o,
  output logic               hilo_we_o
);

`ifdef ALU_CTRL_DIV_EN
  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
`else
  // MUL_CYCLES is at least 1, so DIV_CYCLES never contributes here.
  localparam int unsigned CNT_MAX = (MUL_CYCLES > 32'd0) ? MUL_CYCLES : DIV_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 32'd1);

  logic [3:0]       alu_ctrl_s;
  logic             unknown_s;
  logic             md_op_s;
  logic             md_div_s;
  logic             md_signed_s;
  logic             hilo_rd_s;
  logic             accept_s;
  logic             busy_s;
  logic             stall_s;
  logic             cnt_busy_s;
  logic             cnt_last_s;
  logic [CNT_W-1:0] load_val_s;
  md_state_e        state_r;
  md_state_e        state_nxt_s;

  // Instruction decode: funct for R-type, otherwise the ALUOp class.
  always_comb begin
    alu_ctrl_s  = ALU_AND;
    unknown_s   = 1'b0;
    md_op_s     = 1'b0;
    md_div_s    = 1'b0;
    md_signed_s = 1'b0;
    hilo_rd_s   = 1'b0;
    case (ALUOp_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:   alu_ctrl_s = ALU_ADD;
          FN_SUB:   alu_ctrl_s = ALU_SUB;
          FN_AND:   alu_ctrl_s = ALU_AND;
          FN_OR:    alu_ctrl_s = ALU_OR;
          FN_SLT:   alu_ctrl_s = ALU_SLT;
          FN_SLTU:  alu_ctrl_s = ALU_SLTU;
          FN_SRA:   alu_ctrl_s = ALU_SRA;
          FN_SRAV:  alu_ctrl_s = ALU_SRAV;
          FN_MFHI: begin
            alu_ctrl_s = ALU_MFHI;
            hilo_rd_s  = 1'b1;
          end
          FN_MFLO: begin
            alu_ctrl_s = ALU_MFLO;
            hilo_rd_s  = 1'b1;
          end
          FN_MULT: begin
            alu_ctrl_s  = ALU_MUL;
            md_op_s     = 1'b1;
            md_signed_s = 1'b1;
          end
          FN_MULTU: begin
            alu_ctrl_s = ALU_MUL;
            md_op_s    = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          FN_DIV: begin
            alu_ctrl_s  = ALU_DIV;
            md_op_s     = 1'b1;
            md_div_s    = 1'b1;
            md_signed_s = 1'b1;
          end
          FN_DIVU: begin
            alu_ctrl_s = ALU_DIV;
            md_op_s    = 1'b1;
            md_div_s   = 1'b1;
          end
`endif
          default:  unknown_s = 1'b1;
        endcase
      end
      OP_BEQ:   alu_ctrl_s = ALU_SUB;
      OP_ADDI:  alu_ctrl_s = ALU_ADD;
      OP_SLTIU: alu_ctrl_s = ALU_SLTU;
      OP_ORI:   alu_ctrl_s = ALU_OR;
      OP_LUI:   alu_ctrl_s = ALU_LUI;
      default:  unknown_s  = 1'b1;
    endcase
  end

  assign busy_s   = (state_r == ST_MD);
  assign stall_s  = valid_i & busy_s & (md_op_s | hilo_rd_s);
  assign accept_s = ~rst_i & valid_i & md_op_s & ~stall_s & ~flush_i & (state_r == ST_IDLE);

`ifdef ALU_CTRL_DIV_EN
  assign load_val_s = md_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
`else
  assign load_val_s = CNT_W'(MUL_CYCLES);
`endif

  md_seq_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (accept_s),
    .load_val (load_val_s),
    .abort    (flush_i & busy_s),
    .busy     (cnt_busy_s),
    .last     (cnt_last_s)
  );

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: leave MD on the last counted cycle or on flush.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_MD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MD: begin
        if (flush_i || cnt_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign ALUCtrl_o   = CTRL_W'(alu_ctrl_s);
  assign illegal_o   = valid_i & unknown_s;
  assign md_start_o  = accept_s;
  assign md_div_o    = accept_s & md_div_s;
  assign md_signed_o = accept_s & md_signed_s;
  assign busy_o      = busy_s;
  assign stall_o     = stall_s;
  // A flushed or reset completion must not update HI/LO.
  assign hilo_we_o   = ~rst_i & ~flush_i & busy_s & cnt_busy_s & cnt_last_s;

endmodule
